// File: rtl/data_mem_responder.sv
// Load/store memory responder: byte-addressed little-endian RAM behind a
// valid/ready request port, answering each request after LATENCY cycles.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int WIDX_W = ADDR_WIDTH - 2;
  localparam int WORDS  = 2 ** WIDX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  // Four byte lanes; aligned accesses never straddle a word, so one word
  // index addresses every lane touched by a request.
  logic [7:0] mem [4][WORDS];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  accept_s;
  logic                  we_s;
  logic                  err_s;
  logic [3:0]            be_s;
  logic [31:0]           wlane_s;
  logic [WIDX_W-1:0]     widx_s;
  logic [31:0]           word_s;
  logic [7:0]            byte_s;
  logic [15:0]           half_s;
  logic [DATA_WIDTH-1:0] load_s;

  assign accept_s = req_valid & req_ready_q & rst;
  assign we_s     = accept_s & req_write & ~err_s;
  assign widx_s   = req_addr[ADDR_WIDTH-1:2];

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    err_s = 1'b0;
    be_s  = 4'b0000;
    case (req_size)
      3'b000: be_s = 4'b0001 << req_addr[1:0];
      3'b001: begin
        err_s = req_addr[0];
        be_s  = 4'b0011 << {req_addr[1], 1'b0};
      end
      3'b010: begin
        err_s = (req_addr[1:0] != 2'b00);
        be_s  = 4'b1111;
      end
      3'b100: err_s = req_write;
      3'b101: err_s = req_write | req_addr[0];
      default: err_s = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the byte enables pick the right copy.
  always_comb begin
    case (req_size)
      3'b000:  wlane_s = {4{req_wdata[7:0]}};
      3'b001:  wlane_s = {2{req_wdata[15:0]}};
      default: wlane_s = req_wdata[31:0];
    endcase
  end

  assign word_s = {mem[3][widx_s], mem[2][widx_s], mem[1][widx_s], mem[0][widx_s]};
  assign byte_s = word_s[{req_addr[1:0], 3'b000} +: 8];
  assign half_s = req_addr[1] ? word_s[31:16] : word_s[15:0];

  always_comb begin
    load_s = {DATA_WIDTH{1'b0}};
    if (req_write || err_s) begin
      load_s = {DATA_WIDTH{1'b0}};
    end else begin
      case (req_size)
        3'b000:  load_s = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
        3'b001:  load_s = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
        3'b010:  load_s = DATA_WIDTH'(word_s);
        3'b100:  load_s = {{(DATA_WIDTH-8){1'b0}}, byte_s};
        3'b101:  load_s = {{(DATA_WIDTH-16){1'b0}}, half_s};
        default: load_s = {DATA_WIDTH{1'b0}};
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          rsp_rdata_d = load_s;
          rsp_err_d   = err_s;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    rsp_valid_d = (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_s && be_s[i]) begin
        mem[i][widx_s] <= wlane_s[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's load/store port: accepts one load/store request per transaction over a valid/ready handshake and returns a response after a fixed, parameterised latency.
- Replaces the zero-latency combinational data memory path so that the core's later multicycle/pipelined datapath can be exercised against realistic memory timing.
- Holds a byte-addressed, little-endian RAM of 2**ADDR_WIDTH bytes.
- Supports byte/half/word access with RV32I funct3 size encoding.

Parameters:
- DATA_WIDTH, 32, width of write/read data.
- ADDR_WIDTH, 17, byte-address width; RAM depth is 2**ADDR_WIDTH bytes.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_wdata  in  DATA_WIDTH  store data, low bytes used per size.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  DATA_WIDTH  load result, extended per size; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal size.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- req_ready = 1 only in IDLE. Accept = req_valid & req_ready.
- IDLE:
  - On accept with LATENCY==1, go to RESP.
  - On accept with LATENCY>1, go to WAIT with counter = LATENCY-1.
  - Otherwise stay in IDLE.
- WAIT: decrement the counter each cycle; move to RESP on the cycle the counter reaches 1. rsp_valid is therefore first high exactly LATENCY cycles after the accept edge.
- RESP:
  - rsp_valid = 1.
  - rsp_rdata and rsp_err hold stable until rsp_valid & rsp_ready.
  - On that handshake, return to IDLE.
  - No new request is accepted in the same cycle; back-to-back throughput is one transaction per LATENCY+1 cycles minimum.
- Store commit: bytes are written at the accept edge; per size:
  - SB writes req_wdata[7:0] at addr.
  - SH writes [15:0] at addr, addr+1.
  - SW writes [31:0] at addr..addr+3, little-endian.
- Load sampling: data is sampled at the accept edge (reflects all earlier committed stores), extended, and registered; it is never re-read later.
- Extension: LB/LH sign-extend to DATA_WIDTH; LBU/LHU zero-extend; LW is passed through unchanged.
- Error cases:
  - Half access with addr[0]!=0.
  - Word access with addr[1:0]!=0.
  - req_size in {011, 110, 111}, or 100/101 with req_write=1.
- On error: no RAM write; rsp_err=1; rsp_rdata=0. Latency is unchanged.
- Store responses: rsp_rdata=0, rsp_err=0 unless an error case applies.
- Address range: addresses are taken modulo 2**ADDR_WIDTH; aligned accesses never cross the top of the RAM.
- Request inputs are ignored whenever req_ready=0.
- Reset (rst==0 at a clock edge):
  - State goes to IDLE and the counter clears to 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 from the first edge after reset.
  - Any in-flight transaction is dropped with no response.
  - A store already committed stays committed.
  - RAM contents are not cleared by reset.
  - A request presented during the reset cycle is not accepted.
- rsp_ready held low in RESP: the FSM stalls indefinitely with outputs stable.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> rsp_rdata 0xDEADBEEF, rsp_err 0; rsp_valid rises exactly LATENCY (2) cycles after each accept.
- After the SW above: LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x100 -> 0xFFFFBEEF; LHU 0x102 -> 0x0000DEAD.
- SB 0x101 data 0x12 onto the word above, then LW 0x100 -> 0xDEAD12EF (only byte 1 changed).
- LW 0x102 and SH 0x101 -> rsp_err 1, rsp_rdata 0; subsequent LW 0x100 shows memory unchanged.
- rsp_ready low for 5 cycles in RESP -> rsp_valid/rsp_rdata stable and req_ready 0 throughout; accept completes on the first cycle rsp_ready is high, then req_ready 1 the next cycle.
- Reset asserted 1 cycle after accepting an LW (LATENCY=3) -> rsp_valid never rises for it, req_ready 1 after release; a store accepted before that reset is still readable afterwards.
